s2p_fifo_param: RTL and testbench
=================================

// Module: s2p_fifo_param
// PURPOSE
//  Parametrised serial-to-parallel FIFO feeding the polar decoder word datapath.
//  - Packs a valid-qualified serial bit stream into WORD_W-bit words.
//  - Flushes a zero-padded partial word at frame end and tags it with a last flag.
//  - Buffers words in a DEPTH-entry FIFO with a valid/ready read port, level and sticky overflow.
// PARAMETERS
//  WORD_W     8    bits per parallel word (>=2)
//  DEPTH      200  FIFO entries; any value >=2, not restricted to a power of two
//  MSB_FIRST  1    1: first serial bit -> word[WORD_W-1]; 0: first bit -> word[0]
//  AF_THRESH  DEPTH-4  almost_full threshold (used only with S2P_FIFO_ALMOST_FLAGS_EN)
//  AE_THRESH  4    almost_empty threshold (used only with S2P_FIFO_ALMOST_FLAGS_EN)
// PORTS
//  clk           in   1               clock, all logic on rising edge
//  reset_n       in   1               asynchronous active-low reset
//  serial_in     in   1               serial data bit
//  serial_valid  in   1               serial_in is valid this cycle
//  serial_last   in   1               qualified by serial_valid; this bit ends the frame
//  out_data      out  WORD_W          head word
//  out_last      out  1               head word closed a frame
//  out_valid     out  1               head word available (= !empty)
//  out_ready     in   1               consumer accepts head word
//  empty         out  1               level == 0
//  full          out  1               level == DEPTH
//  level         out  clog2(DEPTH+1)  stored word count
//  overflow      out  1               sticky: a completed word was dropped
//  overflow_clr  in   1               clears overflow
//  almost_full   out  1               macro-only: level >= AF_THRESH
//  almost_empty  out  1               macro-only: level <= AE_THRESH
// BEHAVIOUR
//  Reset (async, reset_n=0):
//  - Pointers, level, bit_cnt, shift register, overflow, out_last and out_data all clear to 0.
//  - Hence empty=1, full=0, out_valid=0.
//  - Reset asserted mid-word discards the partial word; mid-frame drops the rest of the frame.
//  Packing:
//  - Each cycle with serial_valid=1 shifts serial_in in and increments bit_cnt (0..WORD_W-1).
//  - A word completes on the edge where (bit_cnt==WORD_W-1 || serial_last) && serial_valid.
//  - The completing word includes the current bit; bit_cnt returns to 0.
//  - Partial word (serial_last early): unfilled positions are 0.
//    MSB_FIRST=1 pads the low bits; MSB_FIRST=0 pads the high bits.
//  - last tag = serial_last on the completing cycle.
//  - serial_last with serial_valid=0 is ignored.
//  Push and pop:
//  - Push: {last, word} is written at wr_ptr on the completing edge.
//  - Visible at out_valid one cycle later (1-cycle latency, bit to word).
//  - Pop: out_valid && out_ready advances rd_ptr; out_data/out_last are FWFT from mem[rd_ptr].
//  - Pointers wrap DEPTH-1 -> 0 explicitly (no power-of-two masking).
//  - level: +1 on push only, -1 on pop only, unchanged on both.
//  Boundary cases:
//  - Full with simultaneous pop: push is accepted, level stays DEPTH.
//  - Full without pop: word dropped, overflow set, pointers unchanged, bit_cnt still resets.
//  - Empty: out_ready ignored, no underflow, rd_ptr held.
//  - overflow_clr together with a new drop: set wins.
// CONFIGURATION
//  S2P_FIFO_ALMOST_FLAGS_EN
//  - Defined: almost_full/almost_empty ports exist.
//    Both are registered from next-state level, so they are aligned with level.
//    Reset values: almost_full=0, almost_empty=1.
//  - Undefined: both ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package s2p_fifo_pkg:
//  - clog2 function
//  - typedef fifo_entry_t {logic last; logic [WORD_W-1:0] data}
//  - LEVEL_W / PTR_W derivation constants
//  Sub-module s2p_fifo_mem:
//  - Pointer/level/storage core with push/pop/full/empty.
//  - The top level holds the packer, overflow and optional flags.
// TESTING
//  1. Reset, then shift 8 bits 1,0,1,1,0,0,1,0 (MSB_FIRST=1)
//     -> out_data=8'hB2, out_last=0, out_valid rises the cycle after the 8th bit, level=1.
//  2. Frame of 3 bits 1,1,1 with serial_last on the 3rd
//     -> out_data=8'hE0, out_last=1; next word starts from bit_cnt=0.
//  3. Fill 200 words with out_ready=0 -> full=1, level=200.
//     One more word -> overflow=1, level=200, head unchanged.
//     overflow_clr -> overflow=0.
//  4. Full while popping each cycle with continuous input
//     -> every word accepted in order across the 199->0 wrap, overflow stays 0.
//  5. Pulse reset_n low after 5 bits of a word and with 3 words stored
//     -> empty=1, level=0; the next 8 bits form a clean first word.
//  6. With S2P_FIFO_ALMOST_FLAGS_EN, level 195 and 196
//     -> almost_full 0 then 1; at level 4 and 5 -> almost_empty 1 then 0.

Source files
------------

// File: rtl/s2p_fifo_pkg.sv
// s2p_fifo_pkg: sizing helpers and the stored entry layout shared by the
// serial-to-parallel FIFO top level and its storage core.
package s2p_fifo_pkg;

   // Entry layout at the default word width; the top level declares the same
   // {last, data} shape at its configured WORD_W.
   localparam int ENTRY_WORD_W = 8;

   typedef struct packed {
      logic                    last;
      logic [ENTRY_WORD_W-1:0] data;
   } fifo_entry_t;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int level_w(input int depth);
      return clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

endpackage

// File: rtl/s2p_fifo_mem.sv
// s2p_fifo_mem: DEPTH-entry first-word-fall-through store with explicit pointer
// wrap and a level counter. S2P_FIFO_ALMOST_FLAGS_EN exposes the next-state level.
module s2p_fifo_mem
   import s2p_fifo_pkg::*;
#(
   parameter  int WIDTH   = 9,
   parameter  int DEPTH   = 200,
   localparam int PTR_W   = ptr_w(DEPTH),
   localparam int LEVEL_W = level_w(DEPTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               push,
   input  logic [WIDTH-1:0]   din,
   input  logic               pop,
   output logic [WIDTH-1:0]   dout,
   output logic [LEVEL_W-1:0] level,
   output logic               empty,
   output logic               full,
   output logic               drop
`ifdef S2P_FIFO_ALMOST_FLAGS_EN
   ,
   output logic [LEVEL_W-1:0] level_nxt
`endif
);

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LEVEL_W-1:0] level_d;
   logic               do_push;
   logic               do_pop;

   // DEPTH need not be a power of two, so the wrap is a compare, not a mask.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (level == '0);
   assign full    = (level == LEVEL_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign drop    = push && !do_push;
   assign dout    = empty ? '0 : mem[rd_ptr];

`ifdef S2P_FIFO_ALMOST_FLAGS_EN
   assign level_nxt = level_d;
`endif

   always_comb begin
      level_d = level;
      if (do_push && !do_pop) begin
         level_d = level + LEVEL_W'(1);
      end else if (do_pop && !do_push) begin
         level_d = level - LEVEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         level <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/s2p_fifo_param.sv
// s2p_fifo_param: packs a valid-qualified serial stream into WORD_W-bit words and
// queues them with a frame-last tag. Define S2P_FIFO_ALMOST_FLAGS_EN for almost_full/almost_empty.
module s2p_fifo_param
   import s2p_fifo_pkg::*;
#(
   parameter  int WORD_W    = 8,
   parameter  int DEPTH     = 200,
   parameter  bit MSB_FIRST = 1'b1,
`ifdef S2P_FIFO_ALMOST_FLAGS_EN
   parameter  int AF_THRESH = DEPTH - 4,
   parameter  int AE_THRESH = 4,
`endif
   localparam int LEVEL_W   = level_w(DEPTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               serial_in,
   input  logic               serial_valid,
   input  logic               serial_last,
   output logic [WORD_W-1:0]  out_data,
   output logic               out_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               empty,
   output logic               full,
   output logic [LEVEL_W-1:0] level,
   output logic               overflow,
   input  logic               overflow_clr
`ifdef S2P_FIFO_ALMOST_FLAGS_EN
   ,
   output logic               almost_full,
   output logic               almost_empty
`endif
);

   localparam int BCNT_W = clog2(WORD_W);

   typedef struct packed {
      logic              last;
      logic [WORD_W-1:0] data;
   } entry_t;

   logic [BCNT_W-1:0] bit_cnt_p0;
   logic [WORD_W-1:0] shift_p0;
   logic [BCNT_W-1:0] bit_pos;
   logic [WORD_W-1:0] word_p0;
   logic              word_vld_p0;
   entry_t            word_entry;
   entry_t            head;
   logic              drop;
`ifdef S2P_FIFO_ALMOST_FLAGS_EN
   logic [LEVEL_W-1:0] level_nxt;
`endif

   // Packer: the shift register holds only the bits received so far, zeros
   // elsewhere, so a frame-end flush is already zero-padded.
   always_comb begin
      bit_pos     = MSB_FIRST ? (BCNT_W'(WORD_W - 1) - bit_cnt_p0) : bit_cnt_p0;
      word_p0     = shift_p0;
      word_p0[bit_pos] = serial_in;
      word_vld_p0 = serial_valid && ((bit_cnt_p0 == BCNT_W'(WORD_W - 1)) || serial_last);
      word_entry  = '{last: serial_last, data: word_p0};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt_p0 <= '0;
         shift_p0   <= '0;
      end else if (serial_valid) begin
         if (word_vld_p0) begin
            bit_cnt_p0 <= '0;
            shift_p0   <= '0;
         end else begin
            bit_cnt_p0 <= bit_cnt_p0 + BCNT_W'(1);
            shift_p0   <= word_p0;
         end
      end
   end

   // Storage: a completed word is written on the edge that completes it.
   s2p_fifo_mem #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (word_vld_p0),
      .din       (word_entry),
      .pop       (out_ready),
      .dout      (head),
      .level     (level),
      .empty     (empty),
      .full      (full),
      .drop      (drop)
`ifdef S2P_FIFO_ALMOST_FLAGS_EN
      ,
      .level_nxt (level_nxt)
`endif
   );

   assign out_data  = head.data;
   assign out_last  = head.last;
   assign out_valid = !empty;

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (overflow_clr) begin
         overflow <= 1'b0;
      end
   end

`ifdef S2P_FIFO_ALMOST_FLAGS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         almost_full  <= (level_nxt >= LEVEL_W'(AF_THRESH));
         almost_empty <= (level_nxt <= LEVEL_W'(AE_THRESH));
      end
   end
`endif

endmodule

// File: tb/tb_s2p_fifo_param.sv
// tb_s2p_fifo_param: table vectors, directed corner sequences and randomized
// traffic checked against a queue-based model of the serial-to-parallel FIFO.
`timescale 1ns/1ps
module tb_s2p_fifo_param;

   localparam int WORD_W    = 8;
   localparam int DEPTH     = 200;
   localparam int LEVEL_W   = 8;
   localparam int AF_THRESH = DEPTH - 4;
   localparam int AE_THRESH = 4;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               serial_in;
   logic               serial_valid;
   logic               serial_last;
   logic [WORD_W-1:0]  out_data;
   logic               out_last;
   logic               out_valid;
   logic               out_ready;
   logic               empty;
   logic               full;
   logic [LEVEL_W-1:0] level;
   logic               overflow;
   logic               overflow_clr;
`ifdef S2P_FIFO_ALMOST_FLAGS_EN
   logic               almost_full;
   logic               almost_empty;
`endif

   always #5 clk = ~clk;

   s2p_fifo_param #(
      .WORD_W    (WORD_W),
      .DEPTH     (DEPTH),
      .MSB_FIRST (1'b1)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .serial_in    (serial_in),
      .serial_valid (serial_valid),
      .serial_last  (serial_last),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .empty        (empty),
      .full         (full),
      .level        (level),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
`ifdef S2P_FIFO_ALMOST_FLAGS_EN
      ,
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a queue of stored words, the list of bits of the word in
   // progress, and the sticky overflow flag.
   typedef struct packed {
      bit              last;
      bit [WORD_W-1:0] data;
   } ent_t;

   ent_t mq[$];
   bit   pbits[$];
   bit   movf;

   typedef struct {
      bit [7:0] stream;   // serial bits in order, first bit at stream[7]
      int       nbits;
      bit       last;
      bit [7:0] exp_data;
      bit       exp_last;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      pbits.delete();
      movf = 1'b0;
   endfunction

   function automatic void model_edge(input bit sin, input bit sval, input bit slast,
                                      input bit rdy, input bit oclr);
      bit   pop;
      bit   room;
      bit   done;
      ent_t e;
      pop  = rdy && (mq.size() > 0);
      room = (mq.size() < DEPTH) || pop;
      done = 1'b0;
      e    = '0;
      if (sval) begin
         pbits.push_back(sin);
         if (pbits.size() == WORD_W || slast) begin
            done = 1'b1;
            for (int i = 0; i < pbits.size(); i++) e.data[WORD_W-1-i] = pbits[i];
            e.last = slast;
            pbits.delete();
         end
      end
      if (pop) void'(mq.pop_front());
      if (done && room) mq.push_back(e);
      if (done && !room) movf = 1'b1;
      else if (oclr) movf = 1'b0;
   endfunction

   function automatic logic [31:0] exp_state();
      logic [31:0] s;
      ent_t        h;
      s = '0;
      h = (mq.size() > 0) ? mq[0] : '0;
      s[7:0]  = h.data;
      s[8]    = h.last;
      s[16:9] = 8'(mq.size());
      s[17]   = (mq.size() > 0);
      s[18]   = (mq.size() == 0);
      s[19]   = (mq.size() == DEPTH);
      s[20]   = movf;
`ifdef S2P_FIFO_ALMOST_FLAGS_EN
      s[21]   = (mq.size() >= AF_THRESH);
      s[22]   = (mq.size() <= AE_THRESH);
`endif
      return s;
   endfunction

   function automatic logic [31:0] act_state();
      logic [31:0] s;
      s = '0;
      s[7:0]  = out_data;
      s[8]    = out_last;
      s[16:9] = level;
      s[17]   = out_valid;
      s[18]   = empty;
      s[19]   = full;
      s[20]   = overflow;
`ifdef S2P_FIFO_ALMOST_FLAGS_EN
      s[21]   = almost_full;
      s[22]   = almost_empty;
`endif
      return s;
   endfunction

   task automatic step(input bit sin, input bit sval, input bit slast,
                       input bit rdy, input bit oclr);
      serial_in    = sin;
      serial_valid = sval;
      serial_last  = slast;
      out_ready    = rdy;
      overflow_clr = oclr;
      model_edge(sin, sval, slast, rdy, oclr);
      @(posedge clk);
      #1;
      check("state", act_state(), exp_state());
   endtask

   task automatic send_word(input bit [7:0] stream, input int n, input bit last, input bit rdy_on_end);
      for (int i = 0; i < n; i++)
         step(stream[7-i], 1'b1, last && (i == n - 1), rdy_on_end && (i == n - 1), 1'b0);
   endtask

   initial begin
      vecs[0] = '{8'hB2, 8, 1'b0, 8'hB2, 1'b0};
      vecs[1] = '{8'hFF, 3, 1'b1, 8'hE0, 1'b1};
      vecs[2] = '{8'hBF, 5, 1'b1, 8'hB8, 1'b1};
      vecs[3] = '{8'h9F, 1, 1'b1, 8'h80, 1'b1};
      vecs[4] = '{8'h7F, 2, 1'b1, 8'h40, 1'b1};
      vecs[5] = '{8'hFF, 8, 1'b1, 8'hFF, 1'b1};
      vecs[6] = '{8'hC3, 8, 1'b0, 8'hC3, 1'b0};

      reset_n = 1'b0;
      serial_in = 1'b0; serial_valid = 1'b0; serial_last = 1'b0;
      out_ready = 1'b0; overflow_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_data", out_data, 0);
      check("rst_last", out_last, 1'b0);
`ifdef S2P_FIFO_ALMOST_FLAGS_EN
      check("rst_af", almost_full, 1'b0);
      check("rst_ae", almost_empty, 1'b1);
`endif
      reset_n = 1'b1;

      // Table vectors: each word alone in the FIFO, then popped.
      foreach (vecs[v]) begin
         for (int i = 0; i < vecs[v].nbits; i++) begin
            if (i == vecs[v].nbits - 1) check("vec_valid_before", out_valid, 1'b0);
            step(vecs[v].stream[7-i], 1'b1, vecs[v].last && (i == vecs[v].nbits - 1), 1'b0, 1'b0);
         end
         check("vec_valid", out_valid, 1'b1);
         check("vec_data", out_data, vecs[v].exp_data);
         check("vec_last", out_last, vecs[v].exp_last);
         check("vec_level", level, 1);
         step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         check("vec_popped", empty, 1'b1);
      end
      // serial_last without serial_valid must not end a word
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      send_word(8'h6D, 8, 1'b0, 1'b0);
      check("last_unqualified", out_data, 8'h6D);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Fill to full, then overflow
      for (int w = 0; w < DEPTH; w++) send_word(8'(w) ^ 8'h5C, 8, 1'b0, 1'b0);
      check("fill_full", full, 1'b1);
      check("fill_level", level, DEPTH);
      check("fill_head", out_data, 8'h5C);
      check("fill_ovf_clear", overflow, 1'b0);
      send_word(8'hEE, 8, 1'b0, 1'b0);
      check("drop_ovf", overflow, 1'b1);
      check("drop_level", level, DEPTH);
      check("drop_head", out_data, 8'h5C);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("ovf_cleared", overflow, 1'b0);
      for (int i = 0; i < WORD_W; i++) step(1'b1, 1'b1, 1'b0, 1'b0, i == WORD_W - 1);
      check("ovf_set_wins", overflow, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("ovf_cleared2", overflow, 1'b0);

      // Full with a pop on every completing edge, across the pointer wrap
      for (int k = 0; k < 250; k++) begin
         send_word(8'(k * 7 + 3), 8, 1'b0, 1'b1);
         if (k % 50 == 49) begin
            check("fullpop_level", level, DEPTH);
            check("fullpop_ovf", overflow, 1'b0);
         end
      end
      check("fullpop_head", out_data, 8'(50 * 7 + 3));
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("drain_empty", empty, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("empty_pop_level", level, 0);

      // Asynchronous reset mid-word with words stored
      for (int w = 0; w < 3; w++) send_word(8'h11 * 8'(w + 1), 8, 1'b0, 1'b0);
      send_word(8'hF8, 5, 1'b0, 1'b0);
      check("pre_rst_level", level, 3);
      reset_n = 1'b0;
      #3;
      reset_n = 1'b1;
      model_reset();
      #1;
      check("mid_rst_empty", empty, 1'b1);
      check("mid_rst_level", level, 0);
      send_word(8'hA5, 8, 1'b0, 1'b0);
      check("post_rst_data", out_data, 8'hA5);
      check("post_rst_level", level, 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef S2P_FIFO_ALMOST_FLAGS_EN
      for (int w = 1; w <= AF_THRESH; w++) begin
         send_word(8'(w), 8, 1'b0, 1'b0);
         if (w == 4)   check("ae_at_4", almost_empty, 1'b1);
         if (w == 5)   check("ae_at_5", almost_empty, 1'b0);
         if (w == 195) check("af_at_195", almost_full, 1'b0);
         if (w == 196) check("af_at_196", almost_full, 1'b1);
      end
`endif

      // Randomized traffic: slow consumer (fills, overflows), then fast consumer
      for (int c = 0; c < 3000; c++)
         step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 8, $urandom_range(0, 15) == 0,
              $urandom_range(0, 99) < 8, $urandom_range(0, 19) == 0);
      for (int c = 0; c < 3000; c++)
         step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
